seg_display_scanner: RTL and testbench

SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

---
 rtl/seg_display_scanner.sv | 193 +++++++++++++++++++
 tb/tb_seg_display_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Six-digit multiplexed seven-segment scanner with a sequential double-dabble
// binary-to-BCD converter. One of three 16-bit words is converted every 18
// cycles and shown with leading-zero blanking and an optional minus sign.
module seg_display_scanner #(
    parameter int unsigned REFRESH_DIV = 25000,
    parameter bit          SIGNED_MODE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] num1,
    input  logic [15:0] num2,
    input  logic [15:0] result,
    input  logic [1:0]  sel,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        conv_done
);

    localparam int unsigned      PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {StCapture, StShift, StUpdate} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_cnt;
    logic [15:0]      r_mag;
    logic             r_neg;
    logic [19:0]      r_bcd;
    logic [19:0]      r_disp_bcd;
    logic             r_disp_neg;
    logic             r_disp_valid;
    logic             r_conv_done;
    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_idx;
    logic [5:0]       r_an;
    logic [6:0]       r_seg;

    logic [15:0]      w_word;
    logic             w_is_neg;
    logic [15:0]      w_mag;
    logic [19:0]      w_bcd_adj;
    logic [2:0]       w_msd;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_next;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    // Source select and sign/magnitude split of the word to be captured
    always_comb begin
        case (sel)
            2'd0:    w_word = num1;
            2'd1:    w_word = num2;
            default: w_word = result;
        endcase
        w_is_neg = SIGNED_MODE && w_word[15];
        // Negating 16'h8000 yields 16'h8000, which read unsigned is exactly 32768
        w_mag    = w_is_neg ? (~w_word + 16'd1) : w_word;
    end

    // Double-dabble correction: add 3 to every BCD nibble of 5 or more
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StCapture;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Converter FSM next state: CAPTURE -> 16 x SHIFT -> UPDATE, free running
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StCapture: w_state_next = StShift;
            StShift:   if (r_cnt == 4'd15) w_state_next = StUpdate;
            StUpdate:  w_state_next = StCapture;
            default:   w_state_next = StCapture;
        endcase
    end

    // Converter datapath and display registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_mag        <= 16'd0;
            r_neg        <= 1'b0;
            r_bcd        <= 20'd0;
            r_disp_bcd   <= 20'd0;
            r_disp_neg   <= 1'b0;
            r_disp_valid <= 1'b0;
            r_conv_done  <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            case (r_state)
                StCapture: begin
                    r_mag <= w_mag;
                    r_neg <= w_is_neg;
                    r_bcd <= 20'd0;
                    r_cnt <= 4'd0;
                end
                StShift: begin
                    r_bcd <= (w_bcd_adj << 1) | {19'd0, r_mag[15]};
                    r_mag <= r_mag << 1;
                    r_cnt <= r_cnt + 4'd1;
                end
                StUpdate: begin
                    r_disp_bcd   <= r_bcd;
                    r_disp_neg   <= r_neg;
                    r_disp_valid <= 1'b1;
                    r_conv_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Refresh prescaler and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= 3'd0;
        end else if (r_pre == PRE_MAX) begin
            r_pre <= '0;
            r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Segment pattern for the current slot, with leading-zero blanking
    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < 5; i++) begin
            if (r_disp_bcd[4*i +: 4] != 4'd0) w_msd = 3'(i);
        end
        case (r_idx)
            3'd0:    w_digit = r_disp_bcd[3:0];
            3'd1:    w_digit = r_disp_bcd[7:4];
            3'd2:    w_digit = r_disp_bcd[11:8];
            3'd3:    w_digit = r_disp_bcd[15:12];
            3'd4:    w_digit = r_disp_bcd[19:16];
            default: w_digit = 4'd0;
        endcase
        w_seg_next = 7'h7F;
        if (r_idx == 3'd5) begin
            if (r_disp_valid && r_disp_neg) w_seg_next = 7'b0111111;
        end else if (r_disp_valid && (r_idx <= w_msd)) begin
            w_seg_next = f_seg(w_digit);
        end
    end

    // Registered anode and segment drive, fed only from the display registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 6'b111111;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= ~(6'd1 << r_idx);
            r_seg <= w_seg_next;
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = 1'b1;
    assign conv_done = r_conv_done;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner: reset, decimal/negative/zero values,
// input snapshotting, reset mid-conversion and digit refresh sequencing.
module tb_seg_display_scanner;

    localparam logic [6:0] SEG_0  = 7'b1000000;
    localparam logic [6:0] SEG_1  = 7'b1111001;
    localparam logic [6:0] SEG_2  = 7'b0100100;
    localparam logic [6:0] SEG_3  = 7'b0110000;
    localparam logic [6:0] SEG_4  = 7'b0011001;
    localparam logic [6:0] SEG_5  = 7'b0010010;
    localparam logic [6:0] SEG_6  = 7'b0000010;
    localparam logic [6:0] SEG_7  = 7'b1111000;
    localparam logic [6:0] SEG_8  = 7'b0000000;
    localparam logic [6:0] SEG_BL = 7'h7F;
    localparam logic [6:0] SEG_MI = 7'b0111111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] num1 = 16'd0;
    logic [15:0] num2 = 16'd0;
    logic [15:0] result = 16'd0;
    logic [1:0]  sel = 2'd0;
    logic [5:0]  an, an_u;
    logic [6:0]  seg, seg_u;
    logic        dp, dp_u;
    logic        conv_done, conv_done_u;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] s_seg[6];
    logic [6:0] s_seg_u[6];
    bit         s_seen[6];
    int         s_bad;
    logic [6:0] e_seg[6];
    logic [6:0] e_seg_u[6];

    always #5 clk = ~clk;

    seg_display_scanner #(.REFRESH_DIV(4), .SIGNED_MODE(1'b1)) u_dut (
        .clk(clk), .reset(reset), .num1(num1), .num2(num2), .result(result), .sel(sel),
        .an(an), .seg(seg), .dp(dp), .conv_done(conv_done)
    );

    seg_display_scanner #(.REFRESH_DIV(4), .SIGNED_MODE(1'b0)) u_dut_u (
        .clk(clk), .reset(reset), .num1(num1), .num2(num2), .result(result), .sel(sel),
        .an(an_u), .seg(seg_u), .dp(dp_u), .conv_done(conv_done_u)
    );

    // Record the segment pattern seen on each digit slot over ncyc cycles
    task automatic scan(input int ncyc);
        int idx;
        for (int i = 0; i < 6; i++) s_seen[i] = 1'b0;
        s_bad = 0;
        repeat (ncyc) begin
            @(negedge clk);
            case (an)
                6'b111110: idx = 0;
                6'b111101: idx = 1;
                6'b111011: idx = 2;
                6'b110111: idx = 3;
                6'b101111: idx = 4;
                6'b011111: idx = 5;
                default:   idx = -1;
            endcase
            if (idx < 0) begin
                s_bad++;
            end else begin
                s_seg[idx]   = seg;
                s_seg_u[idx] = seg_u;
                s_seen[idx]  = 1'b1;
            end
        end
    endtask

    // Cycles until conv_done is seen high, or -1 when the bound expires
    task automatic wait_conv(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (conv_done === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int first;
        sel = 2'd2; result = 16'd12345;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (an !== 6'b111111) begin n_err++; $display("FAIL reset_an: got %b want 111111", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg: got %b want 1111111", seg); end
        repeat (2) @(negedge clk);
        n_cmp++; if (an !== 6'b111111) begin n_err++; $display("FAIL reset_an_clk: got %b want 111111", an); end
        n_cmp++; if (dp !== 1'b1 || dp_u !== 1'b1) begin n_err++; $display("FAIL reset_dp: got %b/%b want 1", dp, dp_u); end
        n_cmp++; if (conv_done !== 1'b0 || conv_done_u !== 1'b0) begin
            n_err++; $display("FAIL reset_conv_done: got %b/%b want 0", conv_done, conv_done_u);
        end
        n_cmp++; if (an_u !== 6'b111111) begin n_err++; $display("FAIL reset_an_u: got %b want 111111", an_u); end
        reset = 1'b0;
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                n_cmp++; if (an !== 6'b111110) begin n_err++; $display("FAIL release_an: got %b want 111110", an); end
            end
            if (conv_done === 1'b1) begin first = n; break; end
        end
        n_cmp++; if (first != 18) begin n_err++; $display("FAIL first_conv_done: got edge %0d want 18", first); end
    endtask

    task automatic test_decimal;
        int c1, c2;
        scan(24);
        e_seg = '{SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_BL};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (!s_seen[i] || s_seg[i] !== e_seg[i]) begin
                n_err++; $display("FAIL decimal_d%0d: got %b seen %0d want %b", i, s_seg[i], s_seen[i], e_seg[i]);
            end
        end
        n_cmp++; if (s_bad != 0) begin n_err++; $display("FAIL decimal_onehot: got %0d bad an want 0", s_bad); end
        wait_conv(c1);
        @(negedge clk);
        n_cmp++; if (conv_done !== 1'b0) begin n_err++; $display("FAIL conv_done_width: got %b want 0", conv_done); end
        wait_conv(c2);
        n_cmp++; if (c1 < 0 || c2 != 17) begin
            n_err++; $display("FAIL conv_period: got %0d want 18", (c2 < 0) ? c2 : c2 + 1);
        end
    endtask

    task automatic test_negative;
        int c;
        logic [15:0] vals[2];
        vals = '{16'hFFFF, 16'h8000};
        sel = 2'd0;
        for (int v = 0; v < 2; v++) begin
            num1 = vals[v];
            wait_conv(c);
            wait_conv(c);
            n_cmp++; if (c != 18) begin n_err++; $display("FAIL neg_period_%0d: got %0d want 18", v, c); end
            scan(24);
            if (v == 0) begin
                e_seg   = '{SEG_1, SEG_BL, SEG_BL, SEG_BL, SEG_BL, SEG_MI};
                e_seg_u = '{SEG_5, SEG_3, SEG_5, SEG_5, SEG_6, SEG_BL};
            end else begin
                e_seg   = '{SEG_8, SEG_6, SEG_7, SEG_2, SEG_3, SEG_MI};
                e_seg_u = '{SEG_8, SEG_6, SEG_7, SEG_2, SEG_3, SEG_BL};
            end
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (!s_seen[i] || s_seg[i] !== e_seg[i]) begin
                    n_err++; $display("FAIL neg_%h_d%0d: got %b seen %0d want %b", vals[v], i, s_seg[i], s_seen[i], e_seg[i]);
                end
                n_cmp++;
                if (!s_seen[i] || s_seg_u[i] !== e_seg_u[i]) begin
                    n_err++; $display("FAIL uns_%h_d%0d: got %b want %b", vals[v], i, s_seg_u[i], e_seg_u[i]);
                end
            end
        end
    endtask

    task automatic test_zero;
        int c;
        num2 = 16'd0; sel = 2'd1;
        wait_conv(c);
        wait_conv(c);
        n_cmp++; if (c != 18) begin n_err++; $display("FAIL zero_period: got %0d want 18", c); end
        scan(24);
        e_seg = '{SEG_0, SEG_BL, SEG_BL, SEG_BL, SEG_BL, SEG_BL};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (!s_seen[i] || s_seg[i] !== e_seg[i]) begin
                n_err++; $display("FAIL zero_d%0d: got %b seen %0d want %b", i, s_seg[i], s_seen[i], e_seg[i]);
            end
        end
        n_cmp++; if (s_bad != 0) begin n_err++; $display("FAIL zero_onehot: got %0d bad an want 0", s_bad); end
    endtask

    task automatic test_snapshot;
        int c, nseen;
        num1 = 16'hCFC7;   // -12345
        result = 16'd31416;
        sel = 2'd0;
        wait_conv(c);
        wait_conv(c);
        // Next edge captures; four more edges puts us in the 5th shift cycle
        repeat (5) @(negedge clk);
        sel = 2'd2;
        wait_conv(c);
        n_cmp++; if (c != 13) begin n_err++; $display("FAIL snap_latency: got %0d want 13", c); end
        // This conversion is on display for only 18 cycles; check every slot seen
        scan(17);
        e_seg = '{SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_MI};
        nseen = 0;
        for (int i = 0; i < 6; i++) begin
            if (s_seen[i]) begin
                nseen++;
                n_cmp++;
                if (s_seg[i] !== e_seg[i]) begin
                    n_err++; $display("FAIL snap_old_d%0d: got %b want %b", i, s_seg[i], e_seg[i]);
                end
            end
        end
        n_cmp++; if (nseen < 4) begin n_err++; $display("FAIL snap_slots: got %0d slots want >=4", nseen); end
        wait_conv(c);
        n_cmp++; if (c != 1) begin n_err++; $display("FAIL snap_next: got %0d want 1", c); end
        scan(24);
        e_seg = '{SEG_6, SEG_1, SEG_4, SEG_1, SEG_3, SEG_BL};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (!s_seen[i] || s_seg[i] !== e_seg[i]) begin
                n_err++; $display("FAIL snap_new_d%0d: got %b seen %0d want %b", i, s_seg[i], s_seen[i], e_seg[i]);
            end
        end
    endtask

    task automatic test_reset_mid_shift;
        int c, first;
        wait_conv(c);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (an !== 6'b111111) begin n_err++; $display("FAIL midrst_an: got %b want 111111", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL midrst_seg: got %b want 1111111", seg); end
        n_cmp++; if (conv_done !== 1'b0) begin n_err++; $display("FAIL midrst_conv: got %b want 0", conv_done); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (conv_done === 1'b1) begin first = n; break; end
        end
        n_cmp++; if (first != 18) begin n_err++; $display("FAIL midrst_first_conv: got edge %0d want 18", first); end
    endtask

    task automatic test_refresh;
        logic [5:0] exp_an;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 28; j++) begin
            @(negedge clk);
            exp_an = ~(6'd1 << ((j / 4) % 6));
            n_cmp++;
            if (an !== exp_an) begin
                n_err++; $display("FAIL refresh_%0d: got %b want %b", j, an, exp_an);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decimal();
        test_negative();
        test_zero();
        test_snapshot();
        test_reset_mid_shift();
        test_refresh();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
